// File: rtl/x9_pkg.sv
// ============================================================================
// Module      : x9_pkg
// Description : Shared defaults and error-cause encoding for the write-back
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package x9_pkg;
  localparam int c_PW_DEFAULT       = 3;
  localparam int c_LQ_DEPTH_DEFAULT = 4;

  // Bit positions inside the sticky error-cause vector
  localparam int c_ERR_ISSUE_DROP = 0;
  localparam int c_ERR_RET_EMPTY  = 1;
  localparam int c_ERR_CAUSES     = 2;
endpackage

`default_nettype wire

// File: rtl/lq_fifo.sv
// ============================================================================
// Module      : lq_fifo
// Description : In-order load-tag queue; full/empty derive from the
//               registered occupancy so a pop never frees a slot same-cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_PTR_W:0]   c_FULL = DEPTH[c_PTR_W:0];
  localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [c_PTR_W:0]   r_count;
  logic               w_push;
  logic               w_pop;

  assign full   = (r_count == c_FULL);
  assign empty  = (r_count == '0);
  assign head   = r_mem[r_rptr];
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == c_LAST) ? '0 : r_wptr + 1'b1;
      if (w_pop)  r_rptr <= (r_rptr == c_LAST) ? '0 : r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= din;
  end
endmodule

`default_nettype wire

// File: rtl/wb_ctrl.sv
// ============================================================================
// Module      : wb_ctrl
// Description : Register-file write-back arbiter for in-order load returns
//               and ALU results, with a load scoreboard and one ALU hold slot.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_ctrl
  import x9_pkg::*;
#(
  parameter int pw       = c_PW_DEFAULT,
  parameter int LQ_DEPTH = c_LQ_DEPTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               alu_valid,
  input  logic [pw-1:0]      alu_addr,
  input  logic [7:0]         alu_data,
  output logic               alu_ready,
  input  logic               ld_issue,
  input  logic [pw-1:0]      ld_addr,
  output logic               ld_ready,
  input  logic               ld_ret_valid,
  input  logic [7:0]         ld_ret_data,
  input  logic [pw-1:0]      rd_addrA,
  input  logic [pw-1:0]      rd_addrB,
  output logic               stall,
  output logic               wr_en,
  output logic [pw-1:0]      wr_addr,
  output logic [7:0]         dat_in,
  output logic [2**pw-1:0]   busy,
  output logic               err
);
  localparam int c_NREGS = 2**pw;

  logic                    w_lq_full;
  logic                    w_lq_empty;
  logic [pw-1:0]           w_lq_head;
  logic                    w_ld_acc;
  logic                    w_ld_drop;
  logic                    w_ret_acc;
  logic                    w_ret_drop;
  logic                    w_alu_acc;
  logic                    w_hold_drain;
  logic                    w_alu_direct;
  logic                    w_alu_capture;
  logic [c_NREGS-1:0]      w_busy_nxt;
  logic [c_ERR_CAUSES-1:0] w_err_set;

  logic [c_NREGS-1:0]      r_busy;
  logic                    r_hold_valid;
  logic [pw-1:0]           r_hold_addr;
  logic [7:0]              r_hold_data;
  logic                    r_wr_en;
  logic [pw-1:0]           r_wr_addr;
  logic [7:0]              r_dat_in;
  logic [c_ERR_CAUSES-1:0] r_err_cause;

  lq_fifo #(
    .DEPTH (LQ_DEPTH),
    .WIDTH (pw)
  ) u_lq_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_ld_acc),
    .pop   (w_ret_acc),
    .din   (ld_addr),
    .full  (w_lq_full),
    .empty (w_lq_empty),
    .head  (w_lq_head)
  );

  assign ld_ready   = ~w_lq_full & ~r_busy[ld_addr];
  assign alu_ready  = ~r_hold_valid;
  assign w_ld_acc   = ld_issue & ld_ready;
  assign w_ld_drop  = ld_issue & ~ld_ready;
  assign w_ret_acc  = ld_ret_valid & ~w_lq_empty;
  assign w_ret_drop = ld_ret_valid & w_lq_empty;
  assign w_alu_acc  = alu_valid & alu_ready;

  // Load return owns the port; a held result waits for its register to go idle
  assign w_hold_drain  = ~w_ret_acc & r_hold_valid & ~r_busy[r_hold_addr];
  assign w_alu_direct  = w_alu_acc & ~w_ret_acc & ~r_hold_valid & ~r_busy[alu_addr];
  assign w_alu_capture = w_alu_acc & ~w_alu_direct;

  always_comb begin
    w_busy_nxt = r_busy;
    if (w_ret_acc) w_busy_nxt[w_lq_head] = 1'b0;
    if (w_ld_acc)  w_busy_nxt[ld_addr]   = 1'b1;
  end

  always_comb begin
    w_err_set                   = '0;
    w_err_set[c_ERR_ISSUE_DROP] = w_ld_drop;
    w_err_set[c_ERR_RET_EMPTY]  = w_ret_drop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy       <= '0;
      r_hold_valid <= 1'b0;
      r_hold_addr  <= '0;
      r_hold_data  <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_dat_in     <= '0;
      r_err_cause  <= '0;
    end else begin
      r_busy      <= w_busy_nxt;
      r_err_cause <= r_err_cause | w_err_set;
      r_wr_en     <= 1'b0;
      if (w_ret_acc) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= w_lq_head;
        r_dat_in  <= ld_ret_data;
      end else if (w_hold_drain) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= r_hold_addr;
        r_dat_in  <= r_hold_data;
      end else if (w_alu_direct) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= alu_addr;
        r_dat_in  <= alu_data;
      end
      if (w_hold_drain) begin
        r_hold_valid <= 1'b0;
      end else if (w_alu_capture) begin
        r_hold_valid <= 1'b1;
        r_hold_addr  <= alu_addr;
        r_hold_data  <= alu_data;
      end
    end
  end

  assign stall = r_busy[rd_addrA] | r_busy[rd_addrB]
               | (r_hold_valid & ((r_hold_addr == rd_addrA) | (r_hold_addr == rd_addrB)))
               | (r_wr_en & ((r_wr_addr == rd_addrA) | (r_wr_addr == rd_addrB)));

  assign busy    = r_busy;
  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign dat_in  = r_dat_in;
  assign err     = |r_err_cause;
endmodule

`default_nettype wire

// File: tb/tb_wb_ctrl.sv
// ============================================================================
// Module      : tb_wb_ctrl
// Description : Directed scenarios plus randomized traffic for wb_ctrl,
//               compared against a queue-based behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_ctrl;
  localparam int c_LQ = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       alu_valid = 1'b0;
  logic [2:0] alu_addr = '0;
  logic [7:0] alu_data = '0;
  logic       alu_ready;
  logic       ld_issue = 1'b0;
  logic [2:0] ld_addr = '0;
  logic       ld_ready;
  logic       ld_ret_valid = 1'b0;
  logic [7:0] ld_ret_data = '0;
  logic [2:0] rd_addrA = '0;
  logic [2:0] rd_addrB = '0;
  logic       stall;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] dat_in;
  logic [7:0] busy;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: pending tags in issue order, one held ALU result,
  // the write expected on the output port, and the sticky error flag.
  logic [2:0] q[$];
  logic       m_hv, m_wr_en, m_err;
  logic [2:0] m_ha, m_wa;
  logic [7:0] m_hd, m_wd;

  always #5 clk = ~clk;

  wb_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_valid    (alu_valid),
    .alu_addr     (alu_addr),
    .alu_data     (alu_data),
    .alu_ready    (alu_ready),
    .ld_issue     (ld_issue),
    .ld_addr      (ld_addr),
    .ld_ready     (ld_ready),
    .ld_ret_valid (ld_ret_valid),
    .ld_ret_data  (ld_ret_data),
    .rd_addrA     (rd_addrA),
    .rd_addrB     (rd_addrB),
    .stall        (stall),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .dat_in       (dat_in),
    .busy         (busy),
    .err          (err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic inq(input logic [2:0] a);
    foreach (q[i]) if (q[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] busy_vec();
    logic [7:0] v = '0;
    foreach (q[i]) v[q[i]] = 1'b1;
    return v;
  endfunction

  // Entered at a falling edge; drives one cycle, checks, advances the model.
  task automatic cyc(input logic av, input logic [2:0] aa, input logic [7:0] ad,
                     input logic li, input logic [2:0] la,
                     input logic rv, input logic [7:0] rd,
                     input logic [2:0] sa, input logic [2:0] sb);
    logic exp_ldr, exp_stall, ret, drain, direct;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    ld_issue = li; ld_addr = la;
    ld_ret_valid = rv; ld_ret_data = rd;
    rd_addrA = sa; rd_addrB = sb;
    #1;
    exp_ldr   = (q.size() < c_LQ) && !inq(la);
    exp_stall = inq(sa) || inq(sb) || (m_hv && (m_ha == sa || m_ha == sb))
              || (m_wr_en && (m_wa == sa || m_wa == sb));
    check_val("ld_ready", 32'(ld_ready), 32'(exp_ldr));
    check_val("alu_ready", 32'(alu_ready), 32'(!m_hv));
    check_val("stall", 32'(stall), 32'(exp_stall));
    check_val("wr_en", 32'(wr_en), 32'(m_wr_en));
    if (m_wr_en) begin
      check_val("wr_addr", 32'(wr_addr), 32'(m_wa));
      check_val("dat_in", 32'(dat_in), 32'(m_wd));
    end
    check_val("busy", 32'(busy), 32'(busy_vec()));
    check_val("err", 32'(err), 32'(m_err));

    ret    = rv && (q.size() != 0);
    drain  = !ret && m_hv && !inq(m_ha);
    direct = !ret && av && !m_hv && !inq(aa);
    if ((li && !exp_ldr) || (rv && q.size() == 0)) m_err = 1'b1;
    m_wr_en = 1'b0;
    if (ret) begin
      m_wr_en = 1'b1; m_wa = q[0]; m_wd = rd;
    end else if (drain) begin
      m_wr_en = 1'b1; m_wa = m_ha; m_wd = m_hd;
    end else if (direct) begin
      m_wr_en = 1'b1; m_wa = aa; m_wd = ad;
    end
    if (drain) m_hv = 1'b0;
    else if (av && !m_hv && !direct) begin
      m_hv = 1'b1; m_ha = aa; m_hd = ad;
    end
    if (ret) void'(q.pop_front());
    if (li && exp_ldr) q.push_back(la);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [2:0] sa);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, sa, sa);
  endtask

  // Asserts reset off the clock edge so only an asynchronous clear is seen.
  task automatic apply_reset();
    rst_n = 1'b0;
    alu_valid = 0; ld_issue = 0; ld_ret_valid = 0;
    #1;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_wr_en", 32'(wr_en), 32'd0);
    check_val("rst_wr_addr", 32'(wr_addr), 32'd0);
    check_val("rst_dat_in", 32'(dat_in), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    check_val("rst_alu_ready", 32'(alu_ready), 32'd1);
    check_val("rst_ld_ready", 32'(ld_ready), 32'd1);
    q.delete();
    m_hv = 0; m_wr_en = 0; m_err = 0; m_ha = 0; m_hd = 0; m_wa = 0; m_wd = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic random_run(input int n, input int err_pct);
    logic av, li, rv;
    logic [2:0] aa, la;
    for (int i = 0; i < n; i++) begin
      av = 1'($urandom);
      aa = 3'($urandom);
      la = 3'($urandom);
      li = ($urandom_range(0, 99) < 45);
      if (li && (q.size() >= c_LQ || inq(la)) && $urandom_range(0, 99) >= err_pct) li = 1'b0;
      rv = (q.size() != 0) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < err_pct);
      cyc(av, aa, 8'($urandom), li, la, rv, 8'($urandom), 3'($urandom), 3'($urandom));
    end
  endtask

  initial begin
    @(negedge clk);
    apply_reset();

    // Single load to r3, data returned two cycles after issue
    cyc(0, 0, 0, 1, 3, 0, 0, 0, 0);
    check_val("ld3_busy", 32'(busy), 32'h08);
    idle(1, 0);
    cyc(0, 0, 0, 0, 0, 1, 8'hA5, 0, 0);
    check_val("ld3_wr_en", 32'(wr_en), 32'd1);
    check_val("ld3_wr_addr", 32'(wr_addr), 32'd3);
    check_val("ld3_dat", 32'(dat_in), 32'hA5);
    check_val("ld3_busy_clr", 32'(busy), 32'd0);
    idle(1, 0);
    check_val("ld3_wr_once", 32'(wr_en), 32'd0);

    // ALU result colliding with a load return
    cyc(0, 0, 0, 1, 2, 0, 0, 0, 0);
    idle(1, 0);
    cyc(1, 5, 8'h11, 0, 0, 1, 8'h22, 0, 0);
    check_val("col_first_addr", 32'(wr_addr), 32'd2);
    check_val("col_first_dat", 32'(dat_in), 32'h22);
    check_val("col_alu_ready", 32'(alu_ready), 32'd0);
    idle(1, 0);
    check_val("col_second_en", 32'(wr_en), 32'd1);
    check_val("col_second_addr", 32'(wr_addr), 32'd5);
    check_val("col_second_dat", 32'(dat_in), 32'h11);
    check_val("col_alu_ready_back", 32'(alu_ready), 32'd1);
    idle(1, 0);

    // Source-operand hazard on r6
    cyc(0, 0, 0, 1, 6, 0, 0, 6, 1);
    idle(1, 6);
    check_val("haz_stall_busy", 32'(stall), 32'd1);
    cyc(0, 0, 0, 0, 0, 1, 8'hEE, 6, 1);
    check_val("haz_stall_wr", 32'(stall), 32'd1);
    idle(1, 6);
    check_val("haz_stall_clear", 32'(stall), 32'd0);

    // ALU write to a register with a load outstanding is held behind it
    cyc(0, 0, 0, 1, 4, 0, 0, 0, 0);
    cyc(1, 4, 8'h77, 0, 0, 0, 0, 0, 0);
    check_val("hold_alu_ready", 32'(alu_ready), 32'd0);
    check_val("hold_no_wr", 32'(wr_en), 32'd0);
    idle(1, 0);
    cyc(0, 0, 0, 0, 0, 1, 8'h5A, 0, 0);
    check_val("hold_ld_dat", 32'(dat_in), 32'h5A);
    idle(1, 0);
    check_val("hold_final_addr", 32'(wr_addr), 32'd4);
    check_val("hold_final_dat", 32'(dat_in), 32'h77);

    // Fill the queue, overflow it, then drain in order
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 3'(i), 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 4, 0, 0, 0, 0);
    check_val("full_err", 32'(err), 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0, 1, 8'(8'hC0 + i), 0, 0);
      check_val("full_ret_addr", 32'(wr_addr), 32'(i));
    end
    idle(1, 0);
    apply_reset();

    // Reset with two tags pending and a write in flight
    cyc(0, 0, 0, 1, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 2, 0, 0, 0, 0);
    cyc(1, 7, 8'h3C, 0, 0, 0, 0, 0, 0);
    #2;
    apply_reset();
    @(negedge clk);
    cyc(0, 0, 0, 0, 0, 1, 8'h99, 0, 0);
    check_val("post_rst_err", 32'(err), 32'd1);
    check_val("post_rst_no_wr", 32'(wr_en), 32'd0);
    apply_reset();
    @(negedge clk);

    random_run(300, 0);
    apply_reset();
    @(negedge clk);
    random_run(200, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

`default_nettype wire
